// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multiport register file.
// Holds the default geometry, the PC index rule and the write-port priority order.
package regfile_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_NREGS = 16;
  localparam int DEF_NREAD = 3;

  // Write-port identities; the load port beats the ALU port on an address collision.
  localparam int WP_ALU  = 0;
  localparam int WP_LOAD = 1;
  localparam int WP_WIN  = WP_LOAD;
  localparam int WP_LOSE = WP_ALU;

  function automatic int pc_idx(input int nregs);
    return nregs - 1;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set by issue, cleared by write-back, set wins on overlap.
// One-cycle latency from set/clear to busy; no backpressure.
module regfile_scoreboard #(
  parameter int NREGS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREGS-1:0] set_vec,
  input  logic [NREGS-1:0] clr_vec,
  output logic [NREGS-1:0] busy
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~clr_vec) | set_vec;
    end
  end

endmodule

// File: rtl/multiport_register_file.sv
// Two-write, NREAD-read register file with optional write bypass, busy scoreboard and PC-write pulse.
// Reads are combinational, writes/busy/PCWR update on the next edge; never stalls.
module multiport_register_file
  import regfile_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NREGS  = DEF_NREGS,
  parameter int NREAD  = DEF_NREAD,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [NREAD*AW-1:0]    RADDR,
  output logic [NREAD*WIDTH-1:0] RDATA,
  output logic [NREAD-1:0]       RBUSY,
  input  logic [WIDTH-1:0]       PW0,
  input  logic [AW-1:0]          RW0,
  input  logic                   LE0,
  input  logic [WIDTH-1:0]       PW1,
  input  logic [AW-1:0]          RW1,
  input  logic                   LE1,
  input  logic                   ISSUE,
  input  logic [AW-1:0]          ISSUE_RD,
  input  logic [WIDTH-1:0]       PROGCOUNT,
  output logic                   PCWR,
  output logic [WIDTH-1:0]       PCWDATA,
  output logic [NREGS-1:0]       BUSY_VEC
);

  localparam int            PC   = pc_idx(NREGS);
  localparam logic [AW-1:0] PC_A = AW'(PC);

  logic [WIDTH-1:0] pw    [2];
  logic [AW-1:0]    rw    [2];
  logic             le    [2];
  logic             wr_ok [2];

  assign pw[WP_ALU]  = PW0;
  assign rw[WP_ALU]  = RW0;
  assign le[WP_ALU]  = LE0;
  assign pw[WP_LOAD] = PW1;
  assign rw[WP_LOAD] = RW1;
  assign le[WP_LOAD] = LE1;

  // A write lands in storage only for real entries: never the PC, never out of range.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      wr_ok[p] = le[p] && (int'(rw[p]) < PC);
    end
  end

  logic [WIDTH-1:0] regs [PC];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < PC; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < PC; i++) begin
        if (wr_ok[WP_WIN] && int'(rw[WP_WIN]) == i) begin
          regs[i] <= pw[WP_WIN];
        end else if (wr_ok[WP_LOSE] && int'(rw[WP_LOSE]) == i) begin
          regs[i] <= pw[WP_LOSE];
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      PCWR    <= 1'b0;
      PCWDATA <= '0;
    end else if (le[WP_WIN] && rw[WP_WIN] == PC_A) begin
      PCWR    <= 1'b1;
      PCWDATA <= pw[WP_WIN];
    end else if (le[WP_LOSE] && rw[WP_LOSE] == PC_A) begin
      PCWR    <= 1'b1;
      PCWDATA <= pw[WP_LOSE];
    end else begin
      PCWR    <= 1'b0;
    end
  end

  logic [NREGS-1:0] set_vec;
  logic [NREGS-1:0] clr_vec;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (ISSUE && int'(ISSUE_RD) < PC) begin
      set_vec[ISSUE_RD] = 1'b1;
    end
    for (int p = 0; p < 2; p++) begin
      if (wr_ok[p]) begin
        clr_vec[rw[p]] = 1'b1;
      end
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk     (CLK),
    .rst     (RESET),
    .set_vec (set_vec),
    .clr_vec (clr_vec),
    .busy    (BUSY_VEC)
  );

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] stored;
    logic             bsy;
    logic [WIDTH-1:0] rd;

    assign ra = RADDR[k*AW +: AW];

    // Out-of-range addresses match no entry and fall through to zero / not busy.
    always_comb begin
      stored = '0;
      bsy    = 1'b0;
      for (int i = 0; i < PC; i++) begin
        if (int'(ra) == i) begin
          stored = regs[i];
          bsy    = BUSY_VEC[i];
        end
      end
    end

    always_comb begin
      rd = stored;
      if (ra == PC_A) begin
        rd = PROGCOUNT;
      end else if (BYPASS != 0 && wr_ok[WP_WIN] && rw[WP_WIN] == ra) begin
        rd = pw[WP_WIN];
      end else if (BYPASS != 0 && wr_ok[WP_LOSE] && rw[WP_LOSE] == ra) begin
        rd = pw[WP_LOSE];
      end
    end

    assign RDATA[k*WIDTH +: WIDTH] = rd;
    assign RBUSY[k]                = bsy;
  end

endmodule

// File: tb/tb_multiport_register_file.sv
// Directed plus random bench for multiport_register_file, with and without write bypass.
// Expectations come from an array/bitmask model of the architectural register file.
module tb_multiport_register_file;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [11:0] RADDR;
  logic [31:0] PW0, PW1, PROGCOUNT;
  logic [3:0]  RW0, RW1, ISSUE_RD;
  logic        LE0, LE1, ISSUE;

  logic [95:0] rdata_b, rdata_n;
  logic [2:0]  rbusy_b, rbusy_n;
  logic        pcwr_b, pcwr_n;
  logic [31:0] pcwdata_b, pcwdata_n;
  logic [15:0] busy_b, busy_n;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m [16];
  logic [15:0] busy_m;
  logic        pcwr_m;
  logic [31:0] pcwdata_m;

  always #5 CLK = ~CLK;

  multiport_register_file #(.BYPASS(1)) dut_b (
    .CLK(CLK), .RESET(RESET), .RADDR(RADDR), .RDATA(rdata_b), .RBUSY(rbusy_b),
    .PW0(PW0), .RW0(RW0), .LE0(LE0), .PW1(PW1), .RW1(RW1), .LE1(LE1),
    .ISSUE(ISSUE), .ISSUE_RD(ISSUE_RD), .PROGCOUNT(PROGCOUNT),
    .PCWR(pcwr_b), .PCWDATA(pcwdata_b), .BUSY_VEC(busy_b)
  );

  multiport_register_file #(.BYPASS(0)) dut_n (
    .CLK(CLK), .RESET(RESET), .RADDR(RADDR), .RDATA(rdata_n), .RBUSY(rbusy_n),
    .PW0(PW0), .RW0(RW0), .LE0(LE0), .PW1(PW1), .RW1(RW1), .LE1(LE1),
    .ISSUE(ISSUE), .ISSUE_RD(ISSUE_RD), .PROGCOUNT(PROGCOUNT),
    .PCWR(pcwr_n), .PCWDATA(pcwdata_n), .BUSY_VEC(busy_n)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mem_m[i] = '0;
    busy_m    = '0;
    pcwr_m    = 1'b0;
    pcwdata_m = '0;
  endtask

  // Architectural read: PC from fetch, newest write if bypassing, else stored value.
  function automatic logic [31:0] exp_read(input logic [3:0] a, input bit byp);
    if (a == 4'd15) return PROGCOUNT;
    if (byp && LE1 && RW1 == a) return PW1;
    if (byp && LE0 && RW0 == a) return PW0;
    return mem_m[a];
  endfunction

  task automatic model_edge();
    logic [15:0] nb;
    nb = busy_m;
    if (LE0 && RW0 != 4'd15) begin mem_m[RW0] = PW0; nb[RW0] = 1'b0; end
    if (LE1 && RW1 != 4'd15) begin mem_m[RW1] = PW1; nb[RW1] = 1'b0; end
    if (ISSUE && ISSUE_RD != 4'd15) nb[ISSUE_RD] = 1'b1;
    busy_m = nb;
    if (LE1 && RW1 == 4'd15) begin pcwr_m = 1'b1; pcwdata_m = PW1; end
    else if (LE0 && RW0 == 4'd15) begin pcwr_m = 1'b1; pcwdata_m = PW0; end
    else pcwr_m = 1'b0;
  endtask

  task automatic check_all();
    logic [3:0] a;
    for (int k = 0; k < 3; k++) begin
      a = RADDR[k*4 +: 4];
      check("rdata_byp", rdata_b[k*32 +: 32], exp_read(a, 1'b1));
      check("rdata_nobyp", rdata_n[k*32 +: 32], exp_read(a, 1'b0));
      check("rbusy_byp", rbusy_b[k], busy_m[a]);
      check("rbusy_nobyp", rbusy_n[k], busy_m[a]);
    end
    check("busy_vec", busy_b, busy_m);
    check("busy_vec_nb", busy_n, busy_m);
    check("pcwr", {pcwr_n, pcwr_b}, {pcwr_m, pcwr_m});
    check("pcwdata", {pcwdata_n, pcwdata_b}, {pcwdata_m, pcwdata_m});
  endtask

  // Check mid-cycle, take the edge in the model, and return just after the edge.
  task automatic cycle();
    #1;
    check_all();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic idle();
    LE0 = 1'b0; LE1 = 1'b0; ISSUE = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; RADDR = '0; PW0 = '0; PW1 = '0; RW0 = '0; RW1 = '0;
    LE0 = 1'b0; LE1 = 1'b0; ISSUE = 1'b0; ISSUE_RD = '0; PROGCOUNT = 32'h0000_1000;
    model_reset();
    @(posedge CLK); @(posedge CLK); #1;
    RESET = 1'b0;

    // Reset contents
    for (int a = 0; a < 16; a++) begin
      RADDR = {4'((a + 2) % 16), 4'((a + 1) % 16), 4'(a)};
      #1;
      check("reset_read", rdata_b[31:0], (a == 15) ? 32'h0000_1000 : 32'h0);
      cycle();
    end
    check("reset_busy", busy_b, 16'h0);
    check("reset_pcwr", pcwr_b, 1'b0);

    // Same-cycle write of R3
    RADDR = {4'd0, 4'd0, 4'd3};
    LE0 = 1'b1; RW0 = 4'd3; PW0 = 32'hDEAD_BEEF;
    #1;
    check("bypass_r3", rdata_b[31:0], 32'hDEAD_BEEF);
    check("nobypass_r3_old", rdata_n[31:0], 32'h0);
    cycle();
    idle();
    #1;
    check("nobypass_r3_new", rdata_n[31:0], 32'hDEAD_BEEF);
    cycle();

    // Collision on R5
    RADDR = {4'd0, 4'd0, 4'd5};
    LE0 = 1'b1; RW0 = 4'd5; PW0 = 32'h1111_1111;
    LE1 = 1'b1; RW1 = 4'd5; PW1 = 32'h2222_2222;
    #1;
    check("collide_bypass", rdata_b[31:0], 32'h2222_2222);
    cycle();
    idle();
    #1;
    check("collide_stored", rdata_n[31:0], 32'h2222_2222);
    cycle();

    // Scoreboard on R7
    RADDR = {4'd0, 4'd0, 4'd7};
    ISSUE = 1'b1; ISSUE_RD = 4'd7;
    cycle();
    idle();
    #1;
    check("busy_after_issue", rbusy_b[0], 1'b1);
    cycle();
    LE1 = 1'b1; RW1 = 4'd7; PW1 = 32'h0000_0077;
    #1;
    check("busy_at_write", rbusy_b[0], 1'b1);
    cycle();
    idle();
    #1;
    check("busy_cleared", rbusy_b[0], 1'b0);
    ISSUE = 1'b1; ISSUE_RD = 4'd7; LE1 = 1'b1; RW1 = 4'd7; PW1 = 32'h0000_0078;
    cycle();
    idle();
    #1;
    check("set_wins", rbusy_n[0], 1'b1);
    cycle();

    // PC write through port 0, ISSUE to PC ignored
    RADDR = {4'd0, 4'd0, 4'd15};
    LE0 = 1'b1; RW0 = 4'd15; PW0 = 32'h0000_2000;
    #1;
    check("pc_no_bypass", rdata_b[31:0], 32'h0000_1000);
    cycle();
    idle();
    #1;
    check("pcwr_pulse", pcwr_b, 1'b1);
    check("pcwdata", pcwdata_b, 32'h0000_2000);
    check("pc_read_follows", rdata_b[31:0], 32'h0000_1000);
    ISSUE = 1'b1; ISSUE_RD = 4'd15;
    cycle();
    idle();
    #1;
    check("pcwr_one_cycle", pcwr_b, 1'b0);
    check("pc_never_busy", busy_b[15], 1'b0);
    cycle();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      RADDR     = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
      LE0       = 1'($urandom);
      LE1       = 1'($urandom);
      RW0       = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      RW1       = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      PW0       = $urandom;
      PW1       = $urandom;
      ISSUE     = 1'($urandom);
      ISSUE_RD  = 4'($urandom_range(0, 15));
      PROGCOUNT = $urandom;
      cycle();
    end

    // Asynchronous reset mid-cycle
    idle();
    PROGCOUNT = 32'h0000_1000;
    LE0 = 1'b1; RW0 = 4'd1; PW0 = 32'hAAAA_0001;
    LE1 = 1'b1; RW1 = 4'd2; PW1 = 32'hBBBB_0002;
    cycle();
    idle();
    LE0 = 1'b1; RW0 = 4'd15; PW0 = 32'h0000_3000;
    ISSUE = 1'b1; ISSUE_RD = 4'd4;
    cycle();
    idle();
    RADDR = {4'd4, 4'd2, 4'd1};
    #2;
    check("pre_reset_r1", rdata_n[31:0], 32'hAAAA_0001);
    check("pre_reset_pcwr", pcwr_b, 1'b1);
    check("pre_reset_busy4", busy_b[4], 1'b1);
    RESET = 1'b1;
    #1;
    model_reset();
    check("arst_r1", rdata_b[31:0], 32'h0);
    check("arst_r2", rdata_n[63:32], 32'h0);
    check("arst_busy", busy_b, 16'h0);
    check("arst_pcwr", pcwr_b, 1'b0);
    check("arst_pcwdata", pcwdata_b, 32'h0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    cycle();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiport_register_file.md
# multiport_register_file

Parametrised successor to the single-write, three-read ARM register file: WIDTH-bit registers, NREGS entries, NREAD read ports and two write ports (port 0 for ALU results, port 1 for loads). It adds optional same-cycle write bypass, a per-register busy scoreboard for the issue stage, and a registered PC-write pulse. A write addressed to the PC index goes to the fetch stage; it is not stored. It sits between decode/issue (reads, ISSUE) and write-back (write ports), and the fetch stage supplies PROGCOUNT.

## Interface
- WIDTH, 32, register data width
- NREGS, 16, number of architectural registers; index NREGS-1 is the PC
- NREAD, 3, number of read ports
- BYPASS, 1, 1 = reads return same-cycle write data; 0 = reads return stored value only
- AW, $clog2(NREGS), address width (derived, not overridden)
- CLK  in  1  clock, all state updates on rising edge
- RESET  in  1  reset, asynchronous, active-high
- RADDR  in  NREAD*AW  read addresses; port k uses bits [k*AW +: AW]
- RDATA  out  NREAD*WIDTH  read data; port k uses bits [k*WIDTH +: WIDTH]
- RBUSY  out  NREAD  scoreboard bit of each read address
- PW0, RW0, LE0  in  WIDTH, AW, 1  write port 0 (ALU): data, address, enable
- PW1, RW1, LE1  in  WIDTH, AW, 1  write port 1 (load): data, address, enable
- ISSUE, ISSUE_RD  in  1, AW  mark destination ISSUE_RD as pending
- PROGCOUNT  in  WIDTH  current PC from fetch; returned for reads of index NREGS-1
- PCWR  out  1  one-cycle pulse: PC was written through a write port
- PCWDATA  out  WIDTH  target value for PC, valid while PCWR=1
- BUSY_VEC  out  NREGS  full scoreboard

## Operation
- Storage: entries 0..NREGS-2 are flops. Index NREGS-1 has no storage.
- Write: on the rising CLK edge, if LEn=1 and RWn<NREGS-1, entry RWn<=PWn.
- Write collision: if both ports are enabled to the same address, port 1 wins and port 0's data is dropped. Different addresses are both written.
- PC write: if LEn=1 and RWn=NREGS-1, PCWR<=1 and PCWDATA<=PWn on the next edge (port 1 wins if both ports target the PC). Otherwise PCWR<=0, and PCWDATA holds its value.
- Read (combinational), each port independent:
  - RADDR=NREGS-1 returns PROGCOUNT. There is never a bypass for the PC.
  - With BYPASS=1: if LE1 and RW1=RADDR, return PW1. Otherwise, if LE0 and RW0=RADDR, return PW0. Otherwise return the stored entry.
  - With BYPASS=0: return the stored entry.
- Scoreboard, busy[i] for i<NREGS-1:
  - Cleared at the edge where either port writes i.
  - Set at the edge where ISSUE=1 and ISSUE_RD=i.
  - If set and clear happen in the same cycle, set wins (a new producer is in flight).
  - busy[NREGS-1] is constant 0, and ISSUE to the PC index is ignored.
- RBUSY[k] = BUSY_VEC[RADDR[k]], taken from the registered scoreboard (no bypass of clears).
- Reset:
  - All entries are 0, BUSY_VEC=0, PCWR=0 and PCWDATA=0, applied immediately on RESET assertion regardless of CLK.
  - A write enabled in the same cycle that RESET deasserts is not taken unless a rising edge occurs with RESET low.
- Out-of-range addresses (≥NREGS when NREGS is not a power of 2): writes are ignored, reads return 0, RBUSY=0.

## Timing
- Write-to-read latency: 0 cycles with BYPASS=1, 1 cycle with BYPASS=0.
- Write-to-busy-clear: the clear is visible on RBUSY one cycle after the write edge.
- ISSUE-to-busy: visible one cycle after the ISSUE edge.
- PC write to PCWR: 1 cycle. PCWR is high for exactly one cycle per write, and back-to-back PC writes give PCWR high on consecutive cycles.
- No handshake stalls inside the block. Issue logic must check RBUSY and hold ISSUE itself.

## Structure
- Package regfile_pkg holds:
  - default constants (WIDTH 32, NREGS 16, NREAD 3)
  - the PC index function pc_idx(NREGS)
  - the port-select localparams for the collision rule
- Sub-module regfile_scoreboard (NREGS bits, set/clear ports, set-wins rule).
- Storage and read muxes are generated by loops over NREGS and NREAD. The PC path is handled outside those loops.

## Test plan
- Reset, then read all indices with PROGCOUNT=0x0000_1000 -> every RDATA is 0 except index 15, which returns 0x0000_1000; BUSY_VEC=0; PCWR=0.
- Same-cycle write of R3=0xDEAD_BEEF on port 0 while RADDR[0]=3:
  - BYPASS=1: RDATA returns 0xDEAD_BEEF in that cycle.
  - BYPASS=0: returns old 0, then 0xDEAD_BEEF the next cycle.
- Both ports write R5 (port 0 0x1111_1111, port 1 0x2222_2222) -> R5=0x2222_2222 and the bypass read also shows 0x2222_2222.
- ISSUE R7, then port-1 write to R7 two cycles later -> RBUSY high from cycle 1 to the write edge, low after. A simultaneous ISSUE R7 and write to R7 -> R7 stays busy.
- Port-0 write to R15 with 0x0000_2000 -> R15 reads still follow PROGCOUNT; PCWR=1 for one cycle with PCWDATA=0x0000_2000. ISSUE to R15 leaves BUSY_VEC[15]=0.
- Assert RESET asynchronously mid-cycle after writes to R1/R2 and an ISSUE on R4 -> R1=R2=0, BUSY_VEC=0 and PCWR=0 immediately, without waiting for CLK.
